// File: rtl/uart_tx_byte.sv
// Byte-wide 8N1 UART transmitter with a valid/ready byte interface and registered outputs.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 217,
    parameter int CNT_W        = 16
) (
    input  logic       FPGA_CLK,
    input  logic       RST_N,
    input  logic [7:0] TX_DATA,
    input  logic       TX_VALID,
    output logic       TX_READY,
    output logic       TX_DONE,
    output logic       TX_BUSY,
    output logic       UART_TXD
);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;
`endif

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             txd_q, txd_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif
    logic             bit_end;

    assign bit_end = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                txd_d = 1'b1;
                if (TX_VALID && ready_q) begin
                    state_d = S_START;
                    shift_d = TX_DATA;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^TX_DATA;
`endif
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    txd_d   = 1'b0;
                end
            end
            S_START: begin
                cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
                if (bit_end) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                    txd_d   = shift_q[0];
                end
            end
            S_DATA: begin
                cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        txd_d   = parity_q;
`else
                        state_d = S_STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                        txd_d = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
                if (bit_end) begin
                    state_d = S_STOP;
                    txd_d   = 1'b1;
                end
            end
`endif
            S_STOP: begin
                cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
                // Returning to IDLE raises READY together with DONE, so a held VALID
                // transfers on the very next edge, leaving exactly one idle-high cycle.
                if (bit_end) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    txd_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
                txd_d   = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge FPGA_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign UART_TXD = txd_q;
    assign TX_READY = ready_q;
    assign TX_BUSY  = busy_q;
    assign TX_DONE  = done_q;

endmodule

// File: tb/tb_uart_tx_byte.sv
// Self-checking bench for uart_tx_byte: line waveform and handshake outputs are compared
// cycle by cycle against a frame model built from the byte value.
module tb_uart_tx_byte;

    localparam int N = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * N;

    logic       FPGA_CLK = 1'b0;
    logic       RST_N;
    logic [7:0] TX_DATA;
    logic       TX_VALID;
    logic       TX_READY, TX_DONE, TX_BUSY, UART_TXD;

    int checks = 0;
    int errors = 0;

    // {UART_TXD, TX_BUSY, TX_DONE, TX_READY} per cycle
    logic [3:0] cap [0:FRAME];

    uart_tx_byte #(.CLKS_PER_BIT(N), .CNT_W(16)) dut (
        .FPGA_CLK (FPGA_CLK),
        .RST_N    (RST_N),
        .TX_DATA  (TX_DATA),
        .TX_VALID (TX_VALID),
        .TX_READY (TX_READY),
        .TX_DONE  (TX_DONE),
        .TX_BUSY  (TX_BUSY),
        .UART_TXD (UART_TXD)
    );

    always #5 FPGA_CLK = ~FPGA_CLK;

    // Expected line level c cycles after the start bit begins.
    function automatic logic exp_bit(input logic [7:0] d, input int c);
        int b;
        b = c / N;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
`ifdef UART_TX_PARITY_EN
        if (b == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    function automatic logic [3:0] exp_cycle(input logic [7:0] d, input int c);
        if (c < FRAME) return {exp_bit(d, c), 3'b100};
        return 4'b1011;
    endfunction

    // Receive-side model: sample each data bit at its centre.
    function automatic logic [7:0] rx_decode();
        logic [7:0] r;
        for (int b = 0; b < 8; b++) r[b] = cap[(b + 1) * N + N / 2][3];
        return r;
    endfunction

    task automatic capture(input int ncyc, input bit scramble);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge FPGA_CLK);
            cap[c] = {UART_TXD, TX_BUSY, TX_DONE, TX_READY};
            if (scramble) TX_DATA = 8'($urandom);
        end
    endtask

    task automatic start_xfer(input logic [7:0] d, input bit keep_valid);
        TX_DATA  = d;
        TX_VALID = 1'b1;
        @(posedge FPGA_CLK);
        #1;
        if (!keep_valid) TX_VALID = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] obs;
        RST_N    = 1'b0;
        TX_VALID = 1'b0;
        TX_DATA  = 8'h00;
        repeat (3) @(negedge FPGA_CLK);
        obs = {UART_TXD, TX_BUSY, TX_DONE, TX_READY};
        checks++;
        if (obs !== 4'b1001) begin
            errors++;
            $display("FAIL reset_held got %b want %b", obs, 4'b1001);
        end
        RST_N = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge FPGA_CLK);
            obs = {UART_TXD, TX_BUSY, TX_DONE, TX_READY};
            checks++;
            if (obs !== 4'b1001) begin
                errors++;
                $display("FAIL reset_idle c=%0d got %b want %b", c, obs, 4'b1001);
            end
        end
    endtask

    task automatic test_single();
        logic [7:0] d = 8'hA5;
        start_xfer(d, 1'b0);
        capture(FRAME + 1, 1'b0);
        for (int c = 0; c <= FRAME; c++) begin
            checks++;
            if (cap[c] !== exp_cycle(d, c)) begin
                errors++;
                $display("FAIL single c=%0d got %b want %b", c, cap[c], exp_cycle(d, c));
            end
        end
        checks++;
        if (rx_decode() !== d) begin
            errors++;
            $display("FAIL single_decode got %h want %h", rx_decode(), d);
        end
    endtask

    task automatic test_data_hold();
        logic [7:0] d = 8'h3C;
        start_xfer(d, 1'b0);
        TX_DATA = 8'hFF;
        capture(FRAME + 1, 1'b0);
        for (int c = 0; c <= FRAME; c++) begin
            checks++;
            if (cap[c] !== exp_cycle(d, c)) begin
                errors++;
                $display("FAIL data_hold c=%0d got %b want %b", c, cap[c], exp_cycle(d, c));
            end
        end
        checks++;
        if (rx_decode() !== d) begin
            errors++;
            $display("FAIL data_hold_decode got %h want %h", rx_decode(), d);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [2] = '{8'h00, 8'hFF};
        start_xfer(bytes[0], 1'b1);
        TX_DATA = bytes[1];
        for (int f = 0; f < 2; f++) begin
            if (f == 1) begin
                @(posedge FPGA_CLK);
                #1;
                TX_VALID = 1'b0;
            end
            capture(FRAME + 1, 1'b0);
            for (int c = 0; c <= FRAME; c++) begin
                checks++;
                if (cap[c] !== exp_cycle(bytes[f], c)) begin
                    errors++;
                    $display("FAIL b2b f=%0d c=%0d got %b want %b", f, c, cap[c], exp_cycle(bytes[f], c));
                end
            end
            checks++;
            if (rx_decode() !== bytes[f]) begin
                errors++;
                $display("FAIL b2b_decode f=%0d got %h want %h", f, rx_decode(), bytes[f]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d = 8'hF0;
        logic [7:0] d2 = 8'h55;
        logic [3:0] obs;
        start_xfer(d, 1'b0);
        repeat (4 * N + 2) @(negedge FPGA_CLK);
        checks++;
        if (UART_TXD !== 1'b0) begin
            errors++;
            $display("FAIL mid_bit3_level got %b want %b", UART_TXD, 1'b0);
        end
        #1;
        RST_N = 1'b0;
        #1;
        obs = {UART_TXD, TX_BUSY, TX_DONE, TX_READY};
        checks++;
        if (obs !== 4'b1001) begin
            errors++;
            $display("FAIL mid_reset_async got %b want %b", obs, 4'b1001);
        end
        repeat (3) @(negedge FPGA_CLK);
        RST_N = 1'b1;
        for (int c = 0; c < 2 * N; c++) begin
            @(negedge FPGA_CLK);
            obs = {UART_TXD, TX_BUSY, TX_DONE, TX_READY};
            checks++;
            if (obs !== 4'b1001) begin
                errors++;
                $display("FAIL mid_reset_idle c=%0d got %b want %b", c, obs, 4'b1001);
            end
        end
        start_xfer(d2, 1'b0);
        capture(FRAME + 1, 1'b0);
        for (int c = 0; c <= FRAME; c++) begin
            checks++;
            if (cap[c] !== exp_cycle(d2, c)) begin
                errors++;
                $display("FAIL after_reset c=%0d got %b want %b", c, cap[c], exp_cycle(d2, c));
            end
        end
    endtask

    task automatic test_parity_bytes();
        logic [7:0] bytes [2] = '{8'h07, 8'h03};
        for (int f = 0; f < 2; f++) begin
            start_xfer(bytes[f], 1'b0);
            capture(FRAME + 1, 1'b0);
            for (int c = 0; c <= FRAME; c++) begin
                checks++;
                if (cap[c] !== exp_cycle(bytes[f], c)) begin
                    errors++;
                    $display("FAIL parity_frame f=%0d c=%0d got %b want %b", f, c, cap[c], exp_cycle(bytes[f], c));
                end
            end
`ifdef UART_TX_PARITY_EN
            checks++;
            if (cap[9 * N + 1][3] !== ((f == 0) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL parity_bit f=%0d got %b want %b", f, cap[9 * N + 1][3], (f == 0) ? 1'b1 : 1'b0);
            end
`endif
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic [3:0] obs;
        int gap;
        for (int i = 0; i < 12; i++) begin
            d   = 8'($urandom);
            gap = $urandom_range(0, 5);
            for (int g = 0; g < gap; g++) begin
                TX_DATA = 8'($urandom);
                @(negedge FPGA_CLK);
                obs = {UART_TXD, TX_BUSY, TX_DONE, TX_READY};
                checks++;
                if (obs !== 4'b1001) begin
                    errors++;
                    $display("FAIL rand_idle i=%0d got %b want %b", i, obs, 4'b1001);
                end
            end
            start_xfer(d, 1'b0);
            capture(FRAME + 1, 1'b1);
            for (int c = 0; c <= FRAME; c++) begin
                checks++;
                if (cap[c] !== exp_cycle(d, c)) begin
                    errors++;
                    $display("FAIL rand i=%0d d=%h c=%0d got %b want %b", i, d, c, cap[c], exp_cycle(d, c));
                end
            end
            checks++;
            if (rx_decode() !== d) begin
                errors++;
                $display("FAIL rand_decode i=%0d got %h want %h", i, rx_decode(), d);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_data_hold();
        test_back_to_back();
        test_reset_mid_frame();
        test_parity_bytes();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_byte.md
Name: uart_tx_byte

Overview:
- Byte-wide UART transmitter: 8N1 serialiser that drives the board's UART TX line back to the host.
- Forms the return path to the UART receive stage.
- Upstream logic (echo/loopback, LED/key status reporting) hands it one byte at a time over a valid/ready handshake.
- Emits a standard frame: start bit, 8 data bits LSB first, optional parity, stop bit.

Parameters:
- CLKS_PER_BIT, 217, FPGA_CLK cycles per UART bit (25 MHz / 115200). Legal range 2..65535.
- CNT_W, 16, width of the internal bit-timing counter. Must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- FPGA_CLK  input  1  system clock; all logic on rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- TX_DATA  input  8  byte to send; sampled only on handshake.
- TX_VALID  input  1  upstream has a byte on TX_DATA.
- TX_READY  output  1  block can accept a byte this cycle.
- TX_DONE  output  1  one-cycle pulse at end of stop bit.
- TX_BUSY  output  1  high while a frame is on the line.
- UART_TXD  output  1  serial line, idle high.

Behaviour:
- Reset (async assert, sync deassert by user):
  - State=IDLE, UART_TXD=1, TX_READY=1, TX_BUSY=0, TX_DONE=0.
  - Bit counter=0, index=0, shift register=0.
- All outputs are registered; no combinational path from TX_VALID or TX_DATA to any output.
- Handshake:
  - Transfer occurs on a rising edge where TX_VALID=1 and TX_READY=1.
  - TX_READY=1 only in IDLE.
  - TX_DATA is latched into the shift register on the transfer edge; later changes to TX_DATA are ignored.
- States:
  - IDLE: UART_TXD=1. On transfer, go to START; TX_READY<=0, TX_BUSY<=1, UART_TXD<=0. The start bit appears on the edge after the transfer edge.
  - START: hold 0 for CLKS_PER_BIT cycles, then go to DATA with index=0.
  - DATA: UART_TXD=shift[0] for CLKS_PER_BIT cycles per bit, LSB first, shift right after each bit. After index 7 completes, go to PARITY (if enabled) or STOP.
  - STOP: hold 1 for CLKS_PER_BIT cycles. On its final cycle: state<=IDLE, TX_DONE<=1 for exactly one cycle, TX_READY<=1, TX_BUSY<=0.
- Bit timing: counter counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary. Every bit is exactly CLKS_PER_BIT cycles; no drift across the frame.
- Frame length: 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity) from first start-bit cycle to end of stop bit.
- Back-to-back frames: if TX_VALID stays high, the next transfer happens on the first cycle TX_READY=1. This gives exactly one extra idle-high cycle between stop bit and next start bit. No byte is dropped or duplicated.
- TX_VALID low in IDLE: line stays 1 indefinitely; counter held at 0.
- TX_VALID deasserted mid-frame: no effect on the current frame.
- Reset mid-frame: UART_TXD returns to 1 immediately (asynchronously) and the frame is abandoned. No TX_DONE pulse. TX_READY=1 after RST_N deasserts.
- TX_DONE and a new transfer may coincide on the cycle after STOP ends. Both are legal and independent.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP, lasting CLKS_PER_BIT cycles.
  - UART_TXD = XOR of the 8 latched data bits (even parity), computed at transfer time.
  - Frame = 11*CLKS_PER_BIT cycles.
- Undefined: PARITY state and parity register are absent; 8N1 frame of 10*CLKS_PER_BIT cycles.

Test Plan:
- Reset: RST_N=0, then release with TX_VALID=0 for 50 cycles -> UART_TXD=1, TX_READY=1, TX_BUSY=0, TX_DONE never pulses.
- Single byte: CLKS_PER_BIT=4, TX_DATA=0xA5 pulsed valid for 1 cycle -> line reads 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. TX_DONE pulses once, 40 cycles after the start bit begins; TX_BUSY high for those 40 cycles.
- Data hold: change TX_DATA from 0x3C to 0xFF the cycle after transfer -> frame still carries 0x3C (bits 0,0,1,1,1,1,0,0).
- Back-to-back: TX_VALID held high with 0x00 then 0xFF -> two complete frames separated by exactly 1 idle-high cycle; two TX_DONE pulses; the receive-side bench model decodes 0x00, 0xFF.
- Reset mid-frame: assert RST_N=0 during data bit 3 -> UART_TXD=1 within the same cycle, no TX_DONE. The next transfer of 0x55 after release produces a clean frame.
- Parity (UART_TX_PARITY_EN defined, CLKS_PER_BIT=4): send 0x07 then 0x03 -> parity bits 1 and 0; frames 44 cycles each.
